gemm_fixed_weights_each_cycle: RTL and testbench

// Weight-stationary SA_SIZE x SA_SIZE systolic GEMM engine.
// - Accepts one activation vector per clock.
// - Each vector is multiplied by a fixed weight matrix held inside the array.
// - One result vector is produced per clock, at a fixed latency of 2*SA_SIZE.
// - Sits between the activation stream source and downstream accumulation logic.
//

---
 rtl/gemm_fixed_weights_each_cycle.sv | 197 +++++++++++++++++++
 tb/tb_gemm_fixed_weights_each_cycle.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_fixed_weights_each_cycle.sv
// Weight-stationary SA_SIZE x SA_SIZE systolic GEMM engine.
// Input register -> per-row skew -> PE grid (u_SA) -> per-column deskew -> output register.
// Each accepted activation vector X yields sum_j X[j]*W[j][i] (mod 2^W) exactly 2N cycles later.

// PE grid that holds the stationary weights and forms the column partial sums.
module GemmSystolicArray #(
  parameter int SA_SIZE = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter logic [WEIGHT_ACTIVATION_SIZE-1:0] WEIGHTS [SA_SIZE][SA_SIZE] = '{default: '0}
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [WEIGHT_ACTIVATION_SIZE-1:0] act_i  [SA_SIZE],
  output logic [WEIGHT_ACTIVATION_SIZE-1:0] psum_o [SA_SIZE]
);

  localparam int N = SA_SIZE;
  localparam int W = WEIGHT_ACTIVATION_SIZE;

  logic [W-1:0] weights_reg [N][N];
  logic [W-1:0] act_q       [N][N];
  logic [W-1:0] psum_q      [N][N];
  logic [W-1:0] actIn       [N][N];
  logic [W-1:0] psumUp      [N][N];
  logic [W-1:0] psum_d      [N][N];

  // Wire each PE to its left neighbour (activation) and upper neighbour (partial sum).
  for (genvar j = 0; j < N; j++) begin : gRow
    for (genvar i = 0; i < N; i++) begin : gCol
      if (i == 0) begin : gActEdge
        assign actIn[j][i] = act_i[j];
      end else begin : gActChain
        assign actIn[j][i] = act_q[j][i-1];
      end
      if (j == 0) begin : gSumEdge
        assign psumUp[j][i] = '0;
      end else begin : gSumChain
        assign psumUp[j][i] = psum_q[j-1][i];
      end
      assign psum_d[j][i] = psumUp[j][i] + actIn[j][i] * weights_reg[j][i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : gBottom
    assign psum_o[i] = psum_q[N-1][i];
  end

  // Weights are (re)loaded only while reset is held and otherwise stay constant.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          weights_reg[j][i] <= WEIGHTS[j][i];
        end
      end
    end
  end

  // Activations shift right and partial sums shift down by one PE per cycle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          act_q[j][i]  <= '0;
          psum_q[j][i] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          act_q[j][i]  <= actIn[j][i];
          psum_q[j][i] <= psum_d[j][i];
        end
      end
    end
  end

endmodule

module gemm_fixed_weights_each_cycle #(
  parameter int SA_SIZE = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter logic [WEIGHT_ACTIVATION_SIZE-1:0] WEIGHTS [SA_SIZE][SA_SIZE] = '{default: '0}
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs  [SA_SIZE],
  output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE],
  output logic                              output_valid
);

  localparam int N  = SA_SIZE;
  localparam int W  = WEIGHT_ACTIVATION_SIZE;
  localparam int CW = $clog2(2 * N + 1);
  localparam logic [CW-1:0] VALID_AT = CW'(2 * N);

  logic [W-1:0]  inReg_q   [N];
  logic [W-1:0]  skewOut   [N];
  logic [W-1:0]  colOut    [N];
  logic [W-1:0]  deskewOut [N];
  logic [W-1:0]  outReg_q  [N];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          valid_q;
  logic          valid_d;

  // Capture the incoming activation vector every non-reset cycle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int j = 0; j < N; j++) inReg_q[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++) inReg_q[j] <= activation_inputs[j];
    end
  end

  // Row j is delayed j cycles so its activation meets the partial sum coming from above.
  for (genvar j = 0; j < N; j++) begin : gSkew
    if (j == 0) begin : gDirect
      assign skewOut[j] = inReg_q[j];
    end else begin : gDelay
      logic [W-1:0] stage_q [j];
      // Shift register of depth j for this row.
      always_ff @(posedge clk) begin
        if (resetn) begin
          for (int s = 0; s < j; s++) stage_q[s] <= '0;
        end else begin
          stage_q[0] <= inReg_q[j];
          for (int s = 1; s < j; s++) stage_q[s] <= stage_q[s-1];
        end
      end
      assign skewOut[j] = stage_q[j-1];
    end
  end

  GemmSystolicArray #(
    .SA_SIZE               (N),
    .WEIGHT_ACTIVATION_SIZE(W),
    .WEIGHTS               (WEIGHTS)
  ) u_SA (
    .clk   (clk),
    .resetn(resetn),
    .act_i (skewOut),
    .psum_o(colOut)
  );

  // Column i finishes i cycles after column 0, so it needs N-1-i extra cycles to line up.
  for (genvar i = 0; i < N; i++) begin : gDeskew
    localparam int D = N - 1 - i;
    if (D == 0) begin : gDirect
      assign deskewOut[i] = colOut[i];
    end else begin : gDelay
      logic [W-1:0] stage_q [D];
      // Shift register of depth N-1-i for this column.
      always_ff @(posedge clk) begin
        if (resetn) begin
          for (int s = 0; s < D; s++) stage_q[s] <= '0;
        end else begin
          stage_q[0] <= colOut[i];
          for (int s = 1; s < D; s++) stage_q[s] <= stage_q[s-1];
        end
      end
      assign deskewOut[i] = stage_q[D-1];
    end
  end

  // Register the aligned result vector.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < N; i++) outReg_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) outReg_q[i] <= deskewOut[i];
    end
  end

  // Count accepted vectors up to 2N; valid latches when the first result reaches the output.
  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    if (count_q != VALID_AT) count_d = count_q + CW'(1);
    if (count_q == VALID_AT) valid_d = 1'b1;
  end

  // Valid tracking state, cleared by reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign activation_outputs = outReg_q;
  assign output_valid       = valid_q;

endmodule

// File: tb/tb_gemm_fixed_weights_each_cycle.sv
// Self-checking bench for gemm_fixed_weights_each_cycle: three instances
// (N=2 directed, N=2 wrap-around, N=4 random) checked against a mat-vec scoreboard.
module tb_gemm_fixed_weights_each_cycle;

  typedef logic [1:0][7:0] vec2_t;
  typedef logic [3:0][7:0] vec4_t;

  localparam logic [7:0] WA [2][2] = '{'{8'd3, 8'd0}, '{8'd0, 8'd2}};
  localparam logic [7:0] WB [2][2] = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
  localparam logic [7:0] WC [4][4] = '{'{8'd17,  8'd200, 8'd3,   8'd99},
                                       '{8'd45,  8'd128, 8'd250, 8'd7},
                                       '{8'd81,  8'd64,  8'd11,  8'd190},
                                       '{8'd233, 8'd5,   8'd142, 8'd76}};

  logic       clk = 1'b0;
  logic       rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
  logic [7:0] inA [2], outA [2];
  logic [7:0] inB [2], outB [2];
  logic [7:0] inC [4], outC [4];
  logic       validA, validB, validC;

  int nCompared   = 0;
  int nMismatched = 0;

  vec2_t expA [$];
  vec2_t expB [$];
  vec4_t expC [$];

  always #5 clk = ~clk;

  gemm_fixed_weights_each_cycle #(.SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .WEIGHTS(WA)) dutA (
    .clk(clk), .resetn(rstA), .activation_inputs(inA), .activation_outputs(outA), .output_valid(validA));
  gemm_fixed_weights_each_cycle #(.SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .WEIGHTS(WB)) dutB (
    .clk(clk), .resetn(rstB), .activation_inputs(inB), .activation_outputs(outB), .output_valid(validB));
  gemm_fixed_weights_each_cycle #(.SA_SIZE(4), .WEIGHT_ACTIVATION_SIZE(8), .WEIGHTS(WC)) dutC (
    .clk(clk), .resetn(rstC), .activation_inputs(inC), .activation_outputs(outC), .output_valid(validC));

  function automatic vec2_t mv2(vec2_t x, input logic [7:0] w [2][2]);
    vec2_t r;
    for (int i = 0; i < 2; i++) begin
      int acc = 0;
      for (int j = 0; j < 2; j++) acc += int'(x[j]) * int'(w[j][i]);
      r[i] = acc[7:0];
    end
    return r;
  endfunction

  function automatic vec4_t mv4(vec4_t x, input logic [7:0] w [4][4]);
    vec4_t r;
    for (int i = 0; i < 4; i++) begin
      int acc = 0;
      for (int j = 0; j < 4; j++) acc += int'(x[j]) * int'(w[j][i]);
      r[i] = acc[7:0];
    end
    return r;
  endfunction

  function automatic vec2_t readA();
    vec2_t r;
    for (int i = 0; i < 2; i++) r[i] = outA[i];
    return r;
  endfunction

  function automatic vec2_t readB();
    vec2_t r;
    for (int i = 0; i < 2; i++) r[i] = outB[i];
    return r;
  endfunction

  function automatic vec4_t readC();
    vec4_t r;
    for (int i = 0; i < 4; i++) r[i] = outC[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveC(vec4_t x);
    for (int j = 0; j < 4; j++) inC[j] = x[j];
  endtask

  function automatic vec4_t randVec4();
    vec4_t r;
    for (int j = 0; j < 4; j++) r[j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic test_reset();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    for (int j = 0; j < 2; j++) begin inA[j] = 8'd0; inB[j] = 8'd0; end
    for (int j = 0; j < 4; j++) inC[j] = 8'd0;
    repeat (3) tick();
    nCompared++;
    if (validA !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_validA got %b want 0", validA); end
    nCompared++;
    if (validB !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_validB got %b want 0", validB); end
    nCompared++;
    if (validC !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_validC got %b want 0", validC); end
    nCompared++;
    if (readA() !== '0) begin nMismatched++; $display("[TB] FAIL reset_outA got %h want 0", readA()); end
    nCompared++;
    if (readB() !== '0) begin nMismatched++; $display("[TB] FAIL reset_outB got %h want 0", readB()); end
    nCompared++;
    if (readC() !== '0) begin nMismatched++; $display("[TB] FAIL reset_outC got %h want 0", readC()); end
  endtask

  task automatic test_directed();
    vec2_t x, got, want;
    expA.delete();
    x[0] = 8'd2; x[1] = 8'd5;
    for (int j = 0; j < 2; j++) inA[j] = x[j];
    expA.push_back(mv2(x, WA));
    rstA = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      got = readA();
      nCompared++;
      if (validA !== (c >= 4)) begin
        nMismatched++;
        $display("[TB] FAIL directed_valid c=%0d got %b want %b", c, validA, (c >= 4));
      end
      if (c == 4 || c == 5) begin
        want = (c == 4) ? {8'd10, 8'd6} : {8'd4, 8'd9};
        nCompared++;
        if (got !== want) begin
          nMismatched++;
          $display("[TB] FAIL directed_const c=%0d got %h want %h", c, got, want);
        end
      end
      if (validA === 1'b1) begin
        nCompared++;
        if (expA.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL directed_sb c=%0d got %h want <empty queue>", c, got);
        end else begin
          want = expA.pop_front();
          if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL directed_sb c=%0d got %h want %h", c, got, want);
          end
        end
      end
      if (c == 0) begin x[0] = 8'd3; x[1] = 8'd2; end
      else x = '0;
      for (int j = 0; j < 2; j++) inA[j] = x[j];
      expA.push_back(mv2(x, WA));
    end
  endtask

  task automatic test_wrap();
    vec2_t x, got, want;
    expB.delete();
    x[0] = 8'd255; x[1] = 8'd255;
    for (int j = 0; j < 2; j++) inB[j] = x[j];
    expB.push_back(mv2(x, WB));
    rstB = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      got = readB();
      nCompared++;
      if (validB !== (c >= 4)) begin
        nMismatched++;
        $display("[TB] FAIL wrap_valid c=%0d got %b want %b", c, validB, (c >= 4));
      end
      if (c == 4) begin
        want = {8'd2, 8'd2};
        nCompared++;
        if (got !== want) begin
          nMismatched++;
          $display("[TB] FAIL wrap_const got %h want %h", got, want);
        end
      end
      if (validB === 1'b1) begin
        nCompared++;
        if (expB.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL wrap_sb c=%0d got %h want <empty queue>", c, got);
        end else begin
          want = expB.pop_front();
          if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL wrap_sb c=%0d got %h want %h", c, got, want);
          end
        end
      end
      x = (c == 0) ? {8'd200, 8'd7} : '0;
      for (int j = 0; j < 2; j++) inB[j] = x[j];
      expB.push_back(mv2(x, WB));
    end
  endtask

  task automatic streamC(input int nCycles, input string tag);
    vec4_t x, got, want;
    for (int c = 0; c < nCycles; c++) begin
      tick();
      got = readC();
      nCompared++;
      if (validC !== (c >= 8)) begin
        nMismatched++;
        $display("[TB] FAIL %s_valid c=%0d got %b want %b", tag, c, validC, (c >= 8));
      end
      if (validC === 1'b1) begin
        nCompared++;
        if (expC.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL %s_sb c=%0d got %h want <empty queue>", tag, c, got);
        end else begin
          want = expC.pop_front();
          if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s_sb c=%0d got %h want %h", tag, c, got, want);
          end
        end
      end
      x = randVec4();
      driveC(x);
      expC.push_back(mv4(x, WC));
    end
  endtask

  task automatic test_valid_timing();
    vec4_t x;
    expC.delete();
    x = randVec4();
    driveC(x);
    expC.push_back(mv4(x, WC));
    rstC = 1'b0;
    streamC(110, "stream");
  endtask

  task automatic test_midstream_reset();
    vec4_t x;
    rstC = 1'b1;
    driveC(randVec4());
    tick();
    nCompared++;
    if (validC !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_valid got %b want 0", validC);
    end
    nCompared++;
    if (readC() !== '0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_out got %h want 0", readC());
    end
    expC.delete();
    x = randVec4();
    driveC(x);
    expC.push_back(mv4(x, WC));
    rstC = 1'b0;
    streamC(24, "midreset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_valid_timing();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
